// File: rtl/pixel_buffer_bank.sv
// pixel_buffer_bank
//   A bank of NUM_BUF independent pixel FIFOs. Each FIFO holds DEPTH words of
//   DATA_W bits. The FIFOs are filled through an address-mapped write port and
//   drained together: one head word from every FIFO forms a column, and the
//   bank hands that column to the convolution datapath on a valid/ready stream.
//
// Ports
//   clk        clock
//   reset_n    synchronous reset, active low
//   wr_en      write strobe
//   wr_addr    write address; the top ROUTE_BITS bits select the region
//   wr_data    pixel word to write
//   wr_bcast   broadcast: write wr_data to every FIFO (all or nothing)
//   wr_ack     one-cycle pulse meaning the previous cycle's write was accepted
//   out_valid  every FIFO holds at least one word
//   out_ready  consumer takes the column this cycle
//   out_data   column; lane i (bits [i*DATA_W +: DATA_W]) is FIFO i's head
//   flush      empties every FIFO and clears the sticky flags
//   buf_empty  per-FIFO empty
//   buf_full   per-FIFO full
//   overflow   sticky: a write was dropped because a target FIFO was full
//   addr_err   sticky: an addressed data-region write named a missing FIFO
//
// NUM_BUF must be at least 2, and DEPTH must be at least 2.
module pixel_buffer_bank #(
  parameter int                    DATA_W     = 32,
  parameter int                    ADDR_W     = 8,
  parameter int                    ROUTE_BITS = 2,
  parameter logic [ROUTE_BITS-1:0] ROUTE_DATA = 2'b10,
  parameter int                    NUM_BUF    = 8,
  parameter int                    DEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      wr_bcast,
  output logic                      wr_ack,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_BUF*DATA_W-1:0] out_data,
  input  logic                      flush,
  output logic [NUM_BUF-1:0]        buf_empty,
  output logic [NUM_BUF-1:0]        buf_full,
  output logic                      overflow,
  output logic                      addr_err
);

  localparam int IDX_W = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0] DEPTH_CNT   = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR    = PTR_W'(DEPTH - 1);
  // One bit wider than the index so NUM_BUF itself is representable.
  localparam logic [IDX_W:0]   NUM_BUF_IDX = (IDX_W + 1)'(NUM_BUF);

  logic               writeHit;
  logic [IDX_W-1:0]   writeIdx;
  logic               idxValid;
  logic               fire;
  logic               allAccept;
  logic               targetBlocked;
  logic               ackNext;
  logic               overflowSet;
  logic               addrErrSet;
  logic [NUM_BUF-1:0] canAccept;
  logic [NUM_BUF-1:0] pushVec;
  logic [NUM_BUF-1:0] idxMatch;
  logic [NUM_BUF-1:0] emptyVec;
  logic [NUM_BUF-1:0] fullVec;

  logic ackReg;
  logic overflowReg;
  logic addrErrReg;

  // Address bits between the route field and the index are don't-care.
  logic unusedAddr;
  assign unusedAddr = ^wr_addr;

  assign writeHit = wr_en && (wr_addr[ADDR_W-1 -: ROUTE_BITS] == ROUTE_DATA);
  assign writeIdx = wr_addr[IDX_W-1:0];
  assign idxValid = {1'b0, writeIdx} < NUM_BUF_IDX;

  // out_valid comes only from registered counts, so it never depends on out_ready.
  assign out_valid = &(~emptyVec);
  assign fire      = out_valid && out_ready;

  assign allAccept     = &canAccept;
  assign targetBlocked = |(idxMatch & ~canAccept);
  assign ackNext       = |pushVec;

  assign overflowSet = writeHit && !flush &&
                       (wr_bcast ? !allAccept : (idxValid && targetBlocked));
  assign addrErrSet  = writeHit && !flush && !wr_bcast && !idxValid;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BUF; gi++) begin : gBuf
      logic [DATA_W-1:0] mem [DEPTH];
      logic [PTR_W-1:0]  rdPtrReg;
      logic [PTR_W-1:0]  wrPtrReg;
      logic [CNT_W-1:0]  countReg;

      assign idxMatch[gi]  = (writeIdx == IDX_W'(gi));
      // A full FIFO still takes a word when the column pops in the same cycle.
      assign canAccept[gi] = (countReg != DEPTH_CNT) || fire;
      assign pushVec[gi]   = writeHit && !flush &&
                             (wr_bcast ? allAccept
                                       : (idxValid && idxMatch[gi] && canAccept[gi]));
      assign emptyVec[gi]  = (countReg == '0);
      assign fullVec[gi]   = (countReg == DEPTH_CNT);

      assign out_data[gi*DATA_W +: DATA_W] = mem[rdPtrReg];

      // Storage is not reset; stale words are never visible because out_valid gates them.
      always_ff @(posedge clk) begin
        if (pushVec[gi]) begin
          mem[wrPtrReg] <= wr_data;
        end
      end

      always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
          rdPtrReg <= '0;
          wrPtrReg <= '0;
          countReg <= '0;
        end else begin
          if (pushVec[gi]) begin
            wrPtrReg <= (wrPtrReg == LAST_PTR) ? '0 : wrPtrReg + PTR_W'(1);
          end
          if (fire) begin
            rdPtrReg <= (rdPtrReg == LAST_PTR) ? '0 : rdPtrReg + PTR_W'(1);
          end
          case ({pushVec[gi], fire})
            2'b10:   countReg <= countReg + CNT_W'(1);
            2'b01:   countReg <= countReg - CNT_W'(1);
            default: ;
          endcase
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      ackReg      <= 1'b0;
      overflowReg <= 1'b0;
      addrErrReg  <= 1'b0;
    end else begin
      ackReg <= ackNext;
      if (overflowSet) begin
        overflowReg <= 1'b1;
      end
      if (addrErrSet) begin
        addrErrReg <= 1'b1;
      end
    end
  end

  assign wr_ack    = ackReg;
  assign overflow  = overflowReg;
  assign addr_err  = addrErrReg;
  assign buf_empty = emptyVec;
  assign buf_full  = fullVec;

endmodule

// File: tb/tb_pixel_buffer_bank.sv
// tb_pixel_buffer_bank
//   Drives two bank instances with one shared stimulus stream: instance A with
//   8 FIFOs of depth 4, instance B with 6 FIFOs of depth 3. Each instance is
//   compared every cycle against a queue-based reference model, and selected
//   points are also checked against fixed expected values.
module tb_pixel_buffer_bank;

  logic        clk = 1'b0;
  logic        rstN;
  logic        wrEn;
  logic [7:0]  wrAddr;
  logic [31:0] wrData;
  logic        wrBcast;
  logic        outReady;
  logic        flush;

  logic         ackA, validA, ovfA, aerrA;
  logic [255:0] outDataA;
  logic [7:0]   bufEmptyA, bufFullA;

  logic         ackB, validB, ovfB, aerrB;
  logic [191:0] outDataB;
  logic [5:0]   bufEmptyB, bufFullB;

  int nAssert = 0;
  int nFail   = 0;
  int cyc     = 0;
  int ackCountA = 0;

  // Reference model: one queue per FIFO, per instance.
  logic [31:0] q [2][8][$];
  bit          ackM  [2];
  bit          ovfM  [2];
  bit          aerrM [2];

  always #5 clk = ~clk;

  pixel_buffer_bank #(.NUM_BUF(8), .DEPTH(4)) dutA (
    .clk(clk), .reset_n(rstN), .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
    .wr_bcast(wrBcast), .wr_ack(ackA), .out_valid(validA), .out_ready(outReady),
    .out_data(outDataA), .flush(flush), .buf_empty(bufEmptyA), .buf_full(bufFullA),
    .overflow(ovfA), .addr_err(aerrA)
  );

  pixel_buffer_bank #(.NUM_BUF(6), .DEPTH(3)) dutB (
    .clk(clk), .reset_n(rstN), .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
    .wr_bcast(wrBcast), .wr_ack(ackB), .out_valid(validB), .out_ready(outReady),
    .out_data(outDataB), .flush(flush), .buf_empty(bufEmptyB), .buf_full(bufFullB),
    .overflow(ovfB), .addr_err(aerrB)
  );

  function automatic int nbOf(input int k);
    return (k == 0) ? 8 : 6;
  endfunction

  function automatic int depOf(input int k);
    return (k == 0) ? 4 : 3;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one clock edge of the rules to the model of instance k.
  task automatic modelStep(input int k);
    int nb, dep, idx;
    bit hit, fire, allAcc;
    nb  = nbOf(k);
    dep = depOf(k);
    hit = wrEn && (wrAddr[7:6] == 2'b10);
    idx = int'(wrAddr) % (1 << $clog2(nb));
    fire = outReady;
    for (int i = 0; i < nb; i++) if (q[k][i].size() == 0) fire = 1'b0;
    ackM[k] = 1'b0;
    if (!rstN || flush) begin
      for (int i = 0; i < 8; i++) q[k][i].delete();
      ovfM[k]  = 1'b0;
      aerrM[k] = 1'b0;
      return;
    end
    if (fire) for (int i = 0; i < nb; i++) void'(q[k][i].pop_front());
    if (hit) begin
      if (wrBcast) begin
        allAcc = 1'b1;
        for (int i = 0; i < nb; i++) if (q[k][i].size() >= dep) allAcc = 1'b0;
        if (allAcc) begin
          for (int i = 0; i < nb; i++) q[k][i].push_back(wrData);
          ackM[k] = 1'b1;
        end else begin
          ovfM[k] = 1'b1;
        end
      end else if (idx >= nb) begin
        aerrM[k] = 1'b1;
      end else if (q[k][idx].size() < dep) begin
        q[k][idx].push_back(wrData);
        ackM[k] = 1'b1;
      end else begin
        ovfM[k] = 1'b1;
      end
    end
  endtask

  task automatic checkAll();
    for (int k = 0; k < 2; k++) begin
      int nb, dep;
      string p;
      logic [255:0] expData, obsData;
      logic [7:0] expE, expF, obsE, obsF;
      logic expV, obsV, obsAck, obsOvf, obsAerr;
      nb  = nbOf(k);
      dep = depOf(k);
      expData = '0;
      expE = '0;
      expF = '0;
      expV = 1'b1;
      for (int i = 0; i < nb; i++) begin
        if (q[k][i].size() == 0) begin
          expE[i] = 1'b1;
          expV = 1'b0;
        end else begin
          expData[i*32 +: 32] = q[k][i][0];
        end
        if (q[k][i].size() == dep) expF[i] = 1'b1;
      end
      if (k == 0) begin
        p = "A"; obsData = outDataA; obsE = bufEmptyA; obsF = bufFullA;
        obsV = validA; obsAck = ackA; obsOvf = ovfA; obsAerr = aerrA;
      end else begin
        p = "B"; obsData = 256'(outDataB); obsE = 8'(bufEmptyB); obsF = 8'(bufFullB);
        obsV = validB; obsAck = ackB; obsOvf = ovfB; obsAerr = aerrB;
      end
      chk({p, " wr_ack"},    256'(obsAck),  256'(ackM[k]));
      chk({p, " out_valid"}, 256'(obsV),    256'(expV));
      chk({p, " buf_empty"}, 256'(obsE),    256'(expE));
      chk({p, " buf_full"},  256'(obsF),    256'(expF));
      chk({p, " overflow"},  256'(obsOvf),  256'(ovfM[k]));
      chk({p, " addr_err"},  256'(obsAerr), 256'(aerrM[k]));
      if (expV) chk({p, " out_data"}, obsData, expData);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    modelStep(0);
    modelStep(1);
    #1;
    cyc++;
    if (ackA) ackCountA++;
    $display("cyc %0d rst_n=%b wr=%b addr=%02h data=%08h bcast=%b rdy=%b flush=%b | A ack=%b vld=%b ovf=%b | B ack=%b vld=%b ovf=%b aerr=%b",
             cyc, rstN, wrEn, wrAddr, wrData, wrBcast, outReady, flush,
             ackA, validA, ovfA, ackB, validB, ovfB, aerrB);
    checkAll();
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input bit b);
    wrEn = 1'b1; wrAddr = a; wrData = d; wrBcast = b;
    cycle();
    wrEn = 1'b0; wrBcast = 1'b0;
  endtask

  task automatic doFlush();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
  endtask

  initial begin
    rstN = 1'b0; wrEn = 1'b0; wrAddr = '0; wrData = '0;
    wrBcast = 1'b0; outReady = 1'b0; flush = 1'b0;

    // Reset state
    cycle();
    cycle();
    chk("A buf_empty after reset", 256'(bufEmptyA), 256'(8'hFF));
    chk("A out_valid after reset", 256'(validA), 256'(1'b0));
    rstN = 1'b1;
    cycle();

    // Addressed fill 0x11..0x88 to 0x80..0x87
    ackCountA = 0;
    for (int i = 0; i < 8; i++) begin
      wr(8'h80 + 8'(i), 32'h11 * (i + 1), 1'b0);
      if (i == 6) chk("A valid before last lane", 256'(validA), 256'(1'b0));
    end
    chk("A ack pulses", 256'(ackCountA), 256'(8));
    chk("A valid after last lane", 256'(validA), 256'(1'b1));
    chk("A lanes", outDataA,
        256'h00000088_00000077_00000066_00000055_00000044_00000033_00000022_00000011);
    chk("B addr_err from 0x86/0x87", 256'(aerrB), 256'(1'b1));
    chk("A addr_err clear", 256'(aerrA), 256'(1'b0));

    // Coefficient-region write is ignored
    wr(8'h40, 32'hDEAD_BEEF, 1'b0);
    chk("A ack on 0x40", 256'(ackA), 256'(1'b0));

    // Broadcast fill, overflow, drain
    doFlush();
    chk("B addr_err after flush", 256'(aerrB), 256'(1'b0));
    for (int j = 0; j < 4; j++) wr(8'h80, 32'hA0 + j, 1'b1);
    chk("A all full", 256'(bufFullA), 256'(8'hFF));
    chk("A overflow before 5th", 256'(ovfA), 256'(1'b0));
    wr(8'h85, 32'hA4, 1'b1);
    chk("A overflow after 5th", 256'(ovfA), 256'(1'b1));
    chk("A no ack on 5th", 256'(ackA), 256'(1'b0));
    outReady = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk("A lane0 pop order", 256'(outDataA[31:0]), 256'(32'hA0 + j));
      chk("A lane7 pop order", 256'(outDataA[255:224]), 256'(32'hA0 + j));
      cycle();
    end
    outReady = 1'b0;
    chk("A valid after drain", 256'(validA), 256'(1'b0));

    // Full + fire + addressed write in the same cycle
    doFlush();
    for (int j = 0; j < 4; j++) wr(8'h80, 32'hB0 + j, 1'b1);
    outReady = 1'b1;
    wr(8'h83, 32'hC3, 1'b0);
    outReady = 1'b0;
    chk("A ack on full+pop write", 256'(ackA), 256'(1'b1));
    chk("A overflow stays 0", 256'(ovfA), 256'(1'b0));
    chk("A only buffer 3 full", 256'(bufFullA), 256'(8'h08));

    // Pointer wrap: push and pop every cycle
    doFlush();
    wr(8'h80, 32'h5000, 1'b1);
    outReady = 1'b1;
    for (int j = 1; j <= 10; j++) wr(8'h80, 32'h5000 + j, 1'b1);
    for (int j = 0; j < 3; j++) cycle();
    outReady = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      wrEn     = ($urandom_range(0, 3) != 0);
      wrAddr   = ($urandom_range(0, 9) < 7) ? (8'h80 | 8'($urandom_range(0, 7))) : 8'($urandom);
      wrData   = $urandom;
      wrBcast  = ($urandom_range(0, 3) == 0);
      outReady = ($urandom_range(0, 2) != 0);
      flush    = ($urandom_range(0, 40) == 0);
      rstN     = ($urandom_range(0, 80) != 0);
      cycle();
    end
    wrEn = 1'b0; wrBcast = 1'b0; outReady = 1'b0; flush = 1'b0; rstN = 1'b1;

    // Flush together with a write and a fire
    doFlush();
    for (int j = 0; j < 5; j++) wr(8'h80, 32'hD0 + j, 1'b1);
    wr(8'h87, 32'hD7, 1'b0);
    outReady = 1'b1; flush = 1'b1;
    wr(8'h81, 32'hE1, 1'b0);
    flush = 1'b0; outReady = 1'b0;
    chk("A empty after flush", 256'(bufEmptyA), 256'(8'hFF));
    chk("A ack after flush", 256'(ackA), 256'(1'b0));
    chk("A overflow after flush", 256'(ovfA), 256'(1'b0));
    chk("B addr_err after flush2", 256'(aerrB), 256'(1'b0));

    // Reset mid-stream
    wr(8'h80, 32'hF0, 1'b1);
    wr(8'h80, 32'hF1, 1'b1);
    outReady = 1'b1; rstN = 1'b0;
    wr(8'h82, 32'hF2, 1'b0);
    rstN = 1'b1; outReady = 1'b0;
    chk("A empty after reset2", 256'(bufEmptyA), 256'(8'hFF));
    chk("A valid after reset2", 256'(validA), 256'(1'b0));
    chk("A ack after reset2", 256'(ackA), 256'(1'b0));
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
